// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
//  loader_state_t : loader FSM encoding
//  SYNC_BYTE_DEF  : default frame start marker
//  BYTE_W / LEN_W : byte width and width of the frame length field (words)
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         BYTE_W        = 8;
  localparam int         LEN_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_WRITE   = 3'd5,
    ST_CSUM    = 3'd6,
    ST_ERR     = 3'd7
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Serial-byte program loader for the MC14500B program RAM.
// Receives SYNC, LEN_HI, LEN_LO, N x {WORD_HI, WORD_LO}, CSUM and writes each
// word to consecutive program addresses.
// Ports:
//  clk, reset          : clock, synchronous active-high reset
//  in_data/in_valid    : incoming byte stream
//  in_ready            : registered; low only during the WRITE cycle
//  prog_write          : one-cycle RAM write strobe
//  prog_address/data   : RAM write address / word
//  cpu_hold            : keep PC/ICU in reset while loading or after a failure
//  done / error        : sticky status of the last load
// Handshake: a byte transfers on a rising edge where in_valid & in_ready are 1.
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH        = 12,
  parameter int         INSTRUCTION_WIDTH = 4,
  parameter int         DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  prog_write,
  output logic [ADDR_WIDTH-1:0] prog_address,
  output logic [DATA_WIDTH-1:0] prog_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  // Largest legal image, held one bit wider than the length field.
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(2**ADDR_WIDTH);

  loader_state_t         state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  prog_write_q, prog_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [BYTE_W-1:0]     hi_q, hi_d;
  logic [BYTE_W-1:0]     acc_q, acc_d;

  logic                  xfer;
  logic [LEN_W-1:0]      len_n;
  logic [15:0]           word_n;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    error_d      = error_q;
    count_d      = count_q;
    len_d        = len_q;
    hi_d         = hi_q;
    acc_d        = acc_q;
    xfer         = in_valid & in_ready_q;
    len_n        = {len_q[15:8], in_data};
    word_n       = {hi_q, in_data};

    case (state_q)
      // ERR keeps its sticky flags but still hunts for a new SYNC.
      ST_IDLE, ST_ERR: begin
        if (xfer && in_data == SYNC_BYTE) begin
          state_d    = ST_LEN_HI;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          acc_d      = '0;
          count_d    = '0;
          addr_d     = '0;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d   = {in_data, len_q[7:0]};
          acc_d   = acc_q + in_data;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d = len_n;
          acc_d = acc_q + in_data;
          if (len_n == '0) begin
            state_d = ST_CSUM;
          end else if ({1'b0, len_n} > MAX_WORDS) begin
            // Oversized image: reject before any write so the address never wraps.
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          acc_d   = acc_q + in_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          data_d  = word_n[DATA_WIDTH-1:0];
          acc_d   = acc_q + in_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        count_d = count_q + LEN_W'(1);
        addr_d  = addr_q + ADDR_WIDTH'(1);
        state_d = (count_q + LEN_W'(1) == len_q) ? ST_CSUM : ST_DATA_HI;
      end
      ST_CSUM: begin
        if (xfer) begin
          if (in_data == acc_q) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobe and ready are registered from the next state, so both line up
    // exactly with the WRITE cycle.
    prog_write_d = (state_d == ST_WRITE);
    in_ready_d   = (state_d != ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      prog_write_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      count_q      <= '0;
      len_q        <= '0;
      hi_q         <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      prog_write_q <= prog_write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
      count_q      <= count_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      acc_q        <= acc_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign prog_write   = prog_write_q;
  assign prog_address = addr_q;
  assign prog_data    = data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives framed byte streams, checks every
// RAM write against an expected queue and checks status outputs per frame.
module tb_program_loader;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          prog_write;
  logic [AW-1:0] prog_address;
  logic [DW-1:0] prog_data;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_errors = 0;
  int gap_max  = 0;
  bit mon_en   = 1'b0;

  // Expected writes, {address, data}.
  logic [AW+DW-1:0] exp_q[$];

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .prog_write   (prog_write),
    .prog_address (prog_address),
    .prog_data    (prog_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write scoreboard and ready/strobe relation, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready_vs_write", {31'b0, in_ready}, {31'b0, ~prog_write});
      if (prog_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {4'b0, prog_address, prog_data}, 32'hFFFF_FFFF);
        end else begin
          check("write_addr_data", {4'b0, prog_address, prog_data}, {4'b0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    int g;
    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (g) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic expect_write(input int addr, input logic [15:0] w);
    exp_q.push_back({AW'(addr), w});
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"},     {31'b0, done},     {31'b0, d});
    check({tag, "_error"},    {31'b0, error},    {31'b0, e});
    check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, h});
  endtask

  task automatic frame1(input logic [7:0] csum);
    send_byte(8'hA5);
    check("f1_hold_after_sync", {31'b0, cpu_hold}, 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(csum);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   {31'b0, in_ready},   32'd1);
    check("rst_prog_write", {31'b0, prog_write}, 32'd0);
    check("rst_address",    {20'b0, prog_address}, 32'd0);
    check("rst_data",       {16'b0, prog_data},  32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // 1: good two-word frame; checksum 00+02+12+34+AB+CD = 0x1C0 -> C0.
    expect_write(0, 16'h1234);
    expect_write(1, 16'hABCD);
    frame1(8'hC0);
    check_status("t1", 1'b1, 1'b0, 1'b0);
    settle();

    // 2: same frame, wrong checksum.
    expect_write(0, 16'h1234);
    expect_write(1, 16'hABCD);
    frame1(8'hC1);
    check_status("t2", 1'b0, 1'b1, 1'b1);
    settle();

    // 3a: empty image.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_status("t3a", 1'b1, 1'b0, 1'b0);
    settle();

    // 3b: length 0x1001 exceeds 4096 words -> error right after LEN_LO.
    send_byte(8'hA5); send_byte(8'h10);
    check("t3b_no_err_yet", {31'b0, error}, 32'd0);
    send_byte(8'h01);
    check_status("t3b", 1'b0, 1'b1, 1'b1);
    send_byte(8'h11); send_byte(8'h22);
    settle();

    // 4: junk then a frame: 00+02+00+01+FF+FF = 0x201 -> 01.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check_status("t4_junk", 1'b0, 1'b1, 1'b1);
    expect_write(0, 16'h0001);
    expect_write(1, 16'hFFFF);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h01);
    check_status("t4", 1'b1, 1'b0, 1'b0);
    settle();

    // 5: frame 1 with random valid gaps.
    gap_max = 3;
    expect_write(0, 16'h1234);
    expect_write(1, 16'hABCD);
    frame1(8'hC0);
    check_status("t5", 1'b1, 1'b0, 1'b0);
    gap_max = 0;
    settle();

    // 6: reset after 3 of 4 words written.
    expect_write(0, 16'h1111);
    expect_write(1, 16'h2222);
    expect_write(2, 16'h3333);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h33);
    @(negedge clk);
    check("t6_exp_empty", exp_q.size(), 0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_in_ready",   {31'b0, in_ready},     32'd1);
    check("t6_prog_write", {31'b0, prog_write},   32'd0);
    check("t6_address",    {20'b0, prog_address}, 32'd0);
    check("t6_data",       {16'b0, prog_data},    32'd0);
    check_status("t6_rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    // 00+01+BE+EF = 0x1AE -> AE.
    expect_write(0, 16'hBEEF);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'hAE);
    check_status("t6", 1'b1, 1'b0, 1'b0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
